// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  // One iteration is performed per result bit.
  localparam int ITER = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // funct[1] selects divide, funct[0] selects unsigned.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// Single combinational iteration: shift-add multiply or restoring divide.
// Multiply: {hi,lo} holds {partial product, remaining multiplier bits}.
// Divide:   hi is the partial remainder, lo shifts dividend out / quotient in.
module muldiv_step #(
  parameter int W = 32
) (
  input  logic         i_is_div,
  input  logic [W-1:0] i_hi,
  input  logic [W-1:0] i_lo,
  input  logic [W-1:0] i_m,
  output logic [W-1:0] o_hi,
  output logic [W-1:0] o_lo
);

  logic [W:0] w_sum;
  logic [W:0] w_shift;
  logic       w_ge;

  // One step of whichever algorithm the mode selects.
  always_comb begin
    w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_m} : {(W+1){1'b0}});
    w_shift = {i_hi, i_lo[W-1]};
    w_ge    = (w_shift >= {1'b0, i_m});
    o_hi    = w_sum[W:1];
    o_lo    = {w_sum[0], i_lo[W-1:1]};
    if (i_is_div) begin
      // When the subtract succeeds the difference is below i_m, so W bits suffice.
      o_hi = w_ge ? (w_shift[W-1:0] - i_m) : w_shift[W-1:0];
      o_lo = {i_lo[W-2:0], w_ge};
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner: iterative mult/multu/div/divu sequencer plus mthi/mtlo/mf stall.
module hilo_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int DATA_W = ITER
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_operand_a,
  input  logic [DATA_W-1:0] i_operand_b,
  input  logic              i_mthi,
  input  logic              i_mtlo,
  input  logic [DATA_W-1:0] i_mt_data,
  input  logic              i_mf_req,
  output logic [DATA_W-1:0] o_hi_out,
  output logic [DATA_W-1:0] o_lo_out,
  output logic              o_busy,
  output logic              o_stall_req,
  output logic              o_done,
  output logic              o_div_zero
);

  localparam int CNT_W = $clog2(DATA_W);

  state_t              r_state, w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_is_div, r_neg_q, r_neg_r, r_dz;
  logic [DATA_W-1:0]   r_whi, r_wlo, r_m;
  logic [DATA_W-1:0]   r_hi, r_lo;
  logic                r_done, r_dzp;

  logic                w_sa, w_sb;
  logic [DATA_W-1:0]   w_abs_a, w_abs_b;
  logic [DATA_W-1:0]   w_step_hi, w_step_lo;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_fix_hi, w_fix_lo;

  muldiv_step #(.W(DATA_W)) u_step (
    .i_is_div (r_is_div),
    .i_hi     (r_whi),
    .i_lo     (r_wlo),
    .i_m      (r_m),
    .o_hi     (w_step_hi),
    .o_lo     (w_step_lo)
  );

  // Operand magnitudes for signed ops; the core always runs unsigned.
  always_comb begin
    w_sa    = op_is_signed(i_op) & i_operand_a[DATA_W-1];
    w_sb    = op_is_signed(i_op) & i_operand_b[DATA_W-1];
    w_abs_a = w_sa ? (~i_operand_a + 1'b1) : i_operand_a;
    w_abs_b = w_sb ? (~i_operand_b + 1'b1) : i_operand_b;
  end

  // Sign fixup applied at completion. With a zero divisor the restoring
  // loop leaves |a| in the remainder and all ones in the quotient, so only
  // the remainder needs its sign restored to reproduce operand_a.
  always_comb begin
    w_prod   = {r_whi, r_wlo};
    w_fix_hi = r_neg_r ? (~r_whi + 1'b1) : r_whi;
    w_fix_lo = r_wlo;
    if (!r_is_div) begin
      if (r_neg_q) w_prod = ~w_prod + 1'b1;
      {w_fix_hi, w_fix_lo} = w_prod;
    end else if (!r_dz && r_neg_q) begin
      w_fix_lo = ~r_wlo + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = RUN;
      RUN:     if (r_cnt == CNT_W'(DATA_W-1)) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    o_busy      = (r_state != IDLE);
    o_stall_req = o_busy & (i_start | i_mf_req | i_mthi | i_mtlo);
  end

  // Datapath: operand latch, iteration, HI/LO update, completion pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_whi    <= '0;
      r_wlo    <= '0;
      r_m      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_dzp    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dzp  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_cnt    <= '0;
            r_is_div <= op_is_div(i_op);
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa & op_is_div(i_op);
            r_dz     <= op_is_div(i_op) & (i_operand_b == '0);
            r_whi    <= '0;
            r_wlo    <= op_is_div(i_op) ? w_abs_a : w_abs_b;
            r_m      <= op_is_div(i_op) ? w_abs_b : w_abs_a;
          end else begin
            if (i_mthi) r_hi <= i_mt_data;
            if (i_mtlo) r_lo <= i_mt_data;
          end
        end
        RUN: begin
          r_whi <= w_step_hi;
          r_wlo <= w_step_lo;
          r_cnt <= r_cnt + 1'b1;
        end
        FIX: begin
          r_hi   <= w_fix_hi;
          r_lo   <= w_fix_lo;
          r_done <= 1'b1;
          r_dzp  <= r_dz;
        end
        default: ;
      endcase
    end
  end

  assign o_hi_out   = r_hi;
  assign o_lo_out   = r_lo;
  assign o_done     = r_done;
  assign o_div_zero = r_dzp;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Randomized bench for hilo_muldiv_ctrl against an arithmetic reference model.
module tb_hilo_muldiv_ctrl;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, mthi = 1'b0, mtlo = 1'b0, mf_req = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, mt_data = '0;
  logic [31:0] hi_out, lo_out;
  logic        busy, stall_req, done, div_zero;

  int          n_cmp = 0, n_err = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  hilo_muldiv_ctrl #(.DATA_W(32)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_op        (op),
    .i_operand_a (a),
    .i_operand_b (b),
    .i_mthi      (mthi),
    .i_mtlo      (mtlo),
    .i_mt_data   (mt_data),
    .i_mf_req    (mf_req),
    .o_hi_out    (hi_out),
    .o_lo_out    (lo_out),
    .o_busy      (busy),
    .o_stall_req (stall_req),
    .o_done      (done),
    .o_div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h exp 0x%08h", tag, got, exp);
    end
  endtask

  // Architectural result of one mult/div, straight from the arithmetic rules.
  task automatic ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] rh, output logic [31:0] rl, output logic rdz);
    logic [63:0] p;
    int          sx, sy;
    rdz = 1'b0;
    case (o)
      2'b00: begin p = {{32{x[31]}}, x} * {{32{y[31]}}, y}; {rh, rl} = p; end
      2'b01: begin p = {32'b0, x} * {32'b0, y};             {rh, rl} = p; end
      default: begin
        if (y == 0) begin
          rl = 32'hFFFF_FFFF; rh = x; rdz = 1'b1;
        end else if (o == 2'b11) begin
          rl = x / y; rh = x % y;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          rl = 32'h8000_0000; rh = 32'h0;
        end else begin
          sx = x; sy = y;
          rl = 32'(sx / sy); rh = 32'(sx % sy);
        end
      end
    endcase
  endtask

  // Issue one op at the current negedge and follow it to completion.
  // poke: from step 10 onward hammer the stall-causing inputs.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit poke);
    logic [31:0] eh, el;
    logic        edz;
    ref_op(o, x, y, eh, el, edz);
    start = 1'b1; op = o; a = x; b = y;
    mthi = 1'($urandom_range(0, 1)); mtlo = 1'($urandom_range(0, 1)); mt_data = $urandom;
    @(posedge clk); @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    chk("busy_e0", 32'(busy), 32'd1);
    for (int s = 1; s <= 33; s++) begin
      if (poke && s >= 10) begin
        mf_req = 1'b1; start = 1'($urandom_range(0, 1));
        mthi = 1'($urandom_range(0, 1)); mtlo = 1'($urandom_range(0, 1)); mt_data = $urandom;
        #1 chk("stall_busy", 32'(stall_req), 32'd1);
      end
      @(posedge clk); @(negedge clk);
      if (s < 33) begin
        chk("done_early", 32'(done), 32'd0);
        chk("busy_run", 32'(busy), 32'd1);
        if (poke || s % 8 == 0) begin
          chk("hi_hold", hi_out, m_hi);
          chk("lo_hold", lo_out, m_lo);
        end
      end
    end
    chk("done", 32'(done), 32'd1);
    chk("div_zero", 32'(div_zero), 32'(edz));
    chk("busy_low", 32'(busy), 32'd0);
    chk("hi", hi_out, eh);
    chk("lo", lo_out, el);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0; mf_req = 1'b0;
    m_hi = eh; m_lo = el;
    @(posedge clk); @(negedge clk);
    chk("done_once", 32'(done), 32'd0);
    chk("dz_once", 32'(div_zero), 32'd0);
    chk("hi_after", hi_out, m_hi);
  endtask

  task automatic mt_write(input logic wh, input logic wl, input logic [31:0] d);
    mthi = wh; mtlo = wl; mt_data = d;
    @(posedge clk); @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    if (wh) m_hi = d;
    if (wl) m_lo = d;
    chk("mt_hi", hi_out, m_hi);
    chk("mt_lo", lo_out, m_lo);
    mf_req = 1'b1;
    #1 chk("mf_idle_nostall", 32'(stall_req), 32'd0);
    mf_req = 1'b0;
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    #1;
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("tp_mult_hi", hi_out, 32'hFFFF_FFFF);
    chk("tp_mult_lo", lo_out, 32'hFFFF_FFFA);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("tp_multu_hi", hi_out, 32'hFFFF_FFFE);
    chk("tp_multu_lo", lo_out, 32'h0000_0001);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("tp_div_hi", hi_out, 32'hFFFF_FFFF);
    chk("tp_div_lo", lo_out, 32'hFFFF_FFFD);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("tp_ovf_hi", hi_out, 32'h0);
    chk("tp_ovf_lo", lo_out, 32'h8000_0000);
    run_op(2'b11, 32'h1234_5678, 32'd0, 1'b0);
    chk("tp_dz_hi", hi_out, 32'h1234_5678);
    chk("tp_dz_lo", lo_out, 32'hFFFF_FFFF);
    run_op(2'b10, 32'h8765_4321, 32'd0, 1'b0);

    // mthi then multu the very next cycle with pipeline pressure mid-run
    mt_write(1'b1, 1'b0, 32'hAAAA_0000);
    chk("tp_mthi", hi_out, 32'hAAAA_0000);
    run_op(2'b01, 32'h0000_1234, 32'h0001_0001, 1'b1);
    mt_write(1'b1, 1'b1, 32'h5A5A_A5A5);

    // reset in the middle of RUN
    start = 1'b1; op = 2'b01; a = 32'hDEAD_BEEF; b = 32'h0000_0100;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (15) begin @(posedge clk); @(negedge clk); end
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_hi", hi_out, 32'd0);
    chk("abort_lo", lo_out, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); @(negedge clk);
      chk("abort_nodone", 32'(done), 32'd0);
    end
    chk("abort_idle", 32'(busy), 32'd0);
    run_op(2'b01, 32'd5, 32'd7, 1'b0);
    chk("fresh_lo", lo_out, 32'd35);
    chk("fresh_hi", hi_out, 32'd0);

    for (int t = 0; t < 30; t++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 9));
        3: rb = -32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(ro, ra, rb, bit'($urandom_range(0, 1)));
      if (t % 7 == 0) mt_write(1'($urandom_range(0, 1)), 1'b1, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Multi-cycle sequencer that owns the HI/LO register pair and executes mult, multu, div and divu iteratively over 32 steps.
- Sits beside the register-file decoder. It is started by the decode stage and serves mthi/mtlo writes and mfhi/mflo reads.
- Raises a stall request when the pipeline touches HI/LO or issues a new mult/div while an operation is in flight.

Parameters:
DATA_W, 32, operand and HI/LO width; the iteration count equals DATA_W.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  mult/div instruction present in decode this cycle
op  in  2  funct[1:0]: 00 mult, 01 multu, 10 div, 11 divu
operand_a  in  DATA_W  rs value (multiplicand / dividend)
operand_b  in  DATA_W  rt value (multiplier / divisor)
mthi  in  1  write mt_data to HI
mtlo  in  1  write mt_data to LO
mt_data  in  DATA_W  rs value for mthi/mtlo
mf_req  in  1  mfhi/mflo present in decode this cycle
hi_out  out  DATA_W  current HI
lo_out  out  DATA_W  current LO
busy  out  1  operation in flight
stall_req  out  1  busy & (start | mf_req | mthi | mtlo)
done  out  1  one-cycle pulse after HI/LO are updated by an operation
div_zero  out  1  pulses with done when the div/divu divisor was 0

Behaviour:
- Reset (reset=0, asynchronous):
  - hi_out=0, lo_out=0, busy=0, done=0, div_zero=0, state=IDLE.
  - Any operation in progress is aborted with no partial HI/LO write.
- States:
  - IDLE: start sampled high at edge E0 latches op, |a|, |b|, the sign bits and the zero-divisor flag. Counter=0; go to RUN. busy is high from E0 onward.
  - RUN: one shift-add (mult) or restoring subtract-shift (div) step per edge. The counter increments each edge. After the 32nd step (edge E32) go to FIX.
  - FIX: at edge E33 apply the sign correction, write HI/LO, clear busy, set done (and div_zero if applicable) for exactly one cycle; go to IDLE.
- Latency: a start at E0 makes the result visible on hi_out/lo_out after E33, i.e. 34 clocks. busy is low in the cycle after E33, and a new start is accepted there.
- Arithmetic:
  - mult/multu: {HI,LO} = 64-bit product.
  - div/divu: LO = quotient, HI = remainder.
  - Signed ops run on magnitudes. The product/quotient is negated when the operand signs differ; the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (div): LO=0x80000000, HI=0 (wraps, no trap).
  - Divisor 0: full latency. LO=0xFFFFFFFF and HI=operand_a, with no sign fixup for either div or divu; div_zero=1 with done.
- mthi/mtlo:
  - Accepted only when not busy; the register is written at the next edge.
  - mthi and mtlo together write both registers.
  - start in the same cycle has priority and the mt write is dropped (the decoder never issues both).
- While busy:
  - start, mthi, mtlo and mf_req are ignored and stall_req is high.
  - The decoder holds the instruction until stall_req falls.
  - hi_out/lo_out keep their pre-operation values until E33.
- mf_req when idle: no stall; hi_out/lo_out are combinationally current, so a value written by mthi at edge N is readable in cycle N+1.
- done and div_zero are registered and never assert outside FIX completion.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11;
  - state encodings IDLE/RUN/FIX;
  - the ITER constant (=DATA_W).
- One sub-module, muldiv_step: a combinational single-iteration unit. It takes the mode and the partial accumulator/remainder/quotient and returns the next values.
- The FSM, counter, sign handling and HI/LO registers stay in hilo_muldiv_ctrl.

Test Plan:
- mult a=0xFFFFFFFE (-2), b=3 -> after 34 clocks HI=0xFFFFFFFF, LO=0xFFFFFFFA, done pulse once, busy low in the next cycle.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- div a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); then div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu a=0x12345678, b=0 -> LO=0xFFFFFFFF, HI=0x12345678, div_zero=1 for exactly the done cycle.
- mthi 0xAAAA0000 when idle, then start multu in the next cycle, with mf_req asserted at cycle 10 -> stall_req=1 from cycle 10 until the cycle busy falls, and hi_out=0xAAAA0000 until E33.
- Assert reset=0 at RUN step 15 -> HI=LO=0, busy=0 immediately, no done pulse; after release, a fresh multu 5*7 gives LO=35, HI=0.
